// File: rtl/lockstep_stagger_unit.sv
// lockstep_stagger_unit
// Staggered-lockstep front end for one OBI channel. Hart 0 leads and owns the
// bus; every trailing hart h receives the bus response delayed by h*STAGGER
// cycles.
// Build option: define LOCKSTEP_CMP_EN to build the request history, the
// warm-up counters and the comparator. Without it the mismatch outputs are
// tied to 0 and clr_mismatch_i is ignored.
module lockstep_stagger_unit #(
  parameter int NHARTS  = 3,
  parameter int STAGGER = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [NHARTS-1:0]                   hart_req_i,
  input  logic [NHARTS-1:0]                   hart_we_i,
  input  logic [NHARTS-1:0][DATA_W/8-1:0]     hart_be_i,
  input  logic [NHARTS-1:0][ADDR_W-1:0]       hart_addr_i,
  input  logic [NHARTS-1:0][DATA_W-1:0]       hart_wdata_i,
  output logic [NHARTS-1:0]                   hart_gnt_o,
  output logic [NHARTS-1:0]                   hart_rvalid_o,
  output logic [NHARTS-1:0][DATA_W-1:0]       hart_rdata_o,
  output logic                                bus_req_o,
  output logic                                bus_we_o,
  output logic [DATA_W/8-1:0]                 bus_be_o,
  output logic [ADDR_W-1:0]                   bus_addr_o,
  output logic [DATA_W-1:0]                   bus_wdata_o,
  input  logic                                bus_gnt_i,
  input  logic                                bus_rvalid_i,
  input  logic [DATA_W-1:0]                   bus_rdata_i,
  input  logic                                clr_mismatch_i,
  output logic                                mismatch_o,
  output logic [NHARTS-1:0]                   mismatch_hart_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = (NHARTS - 1) * STAGGER;
  localparam int RSP_W = 2 + DATA_W;

  // Reject configurations outside the supported range at elaboration.
  if (NHARTS < 2 || NHARTS > 4) begin : g_bad_nharts
    $error("lockstep_stagger_unit: NHARTS must be in 2..4");
  end
  if (STAGGER < 1) begin : g_bad_stagger
    $error("lockstep_stagger_unit: STAGGER must be >= 1");
  end

  // ---------------------------------------------------------------------------
  // Bus path: hart 0 owns the bus, trailing requests never reach it.
  // ---------------------------------------------------------------------------
  assign bus_req_o        = hart_req_i[0];
  assign bus_we_o         = hart_we_i[0];
  assign bus_be_o         = hart_be_i[0];
  assign bus_addr_o       = hart_addr_i[0];
  assign bus_wdata_o      = hart_wdata_i[0];

  assign hart_gnt_o[0]    = bus_gnt_i;
  assign hart_rvalid_o[0] = bus_rvalid_i;
  assign hart_rdata_o[0]  = bus_rdata_i;

  // ---------------------------------------------------------------------------
  // Response replay: one shared delay line, hart h taps stage h*STAGGER-1 so
  // the response reaches it exactly h*STAGGER cycles after the bus.
  // ---------------------------------------------------------------------------
  logic [RSP_W-1:0] rsp_pipe_r [DEPTH];
  logic [RSP_W-1:0] rsp_in_s   [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_rsp_stage
    if (i == 0) begin : g_head
      assign rsp_in_s[i] = {bus_gnt_i, bus_rvalid_i, bus_rdata_i};
    end else begin : g_body
      assign rsp_in_s[i] = rsp_pipe_r[i-1];
    end

    // Advance one replay stage; a disabled unit flushes in-flight responses.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rsp_pipe_r[i] <= '0;
      end else if (!enable_i) begin
        rsp_pipe_r[i] <= '0;
      end else begin
        rsp_pipe_r[i] <= rsp_in_s[i];
      end
    end
  end

  for (genvar h = 1; h < NHARTS; h++) begin : g_trail_rsp
    logic              gnt_s;
    logic              rvalid_s;
    logic [DATA_W-1:0] rdata_s;

    // Present the delayed response only while lockstep is enabled.
    always_comb begin
      if (enable_i) begin
        {gnt_s, rvalid_s, rdata_s} = rsp_pipe_r[h*STAGGER-1];
      end else begin
        gnt_s    = 1'b0;
        rvalid_s = 1'b0;
        rdata_s  = '0;
      end
    end

    assign hart_gnt_o[h]    = gnt_s;
    assign hart_rvalid_o[h] = rvalid_s;
    assign hart_rdata_o[h]  = rdata_s;
  end

`ifdef LOCKSTEP_CMP_EN
  // ---------------------------------------------------------------------------
  // Request history and comparator.
  // ---------------------------------------------------------------------------
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t              hist_r    [DEPTH];
  req_t              hist_in_s [DEPTH];
  logic [NHARTS-1:0] flag_s;
  logic [NHARTS-1:0] flag_nxt_s;
  logic              mismatch_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_hist_stage
    if (i == 0) begin : g_head
      assign hist_in_s[i] = {hart_req_i[0], hart_we_i[0], hart_be_i[0],
                             hart_addr_i[0], hart_wdata_i[0]};
    end else begin : g_body
      assign hist_in_s[i] = hist_r[i-1];
    end

    // Shift hart 0's request history; flushed while disabled.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        hist_r[i] <= '0;
      end else if (!enable_i) begin
        hist_r[i] <= '0;
      end else begin
        hist_r[i] <= hist_in_s[i];
      end
    end
  end

  // The leading hart is never compared against anything.
  assign flag_s[0]     = 1'b0;
  assign flag_nxt_s[0] = 1'b0;

  for (genvar h = 1; h < NHARTS; h++) begin : g_cmp
    localparam logic [CNT_W-1:0] WARM_C = CNT_W'(h * STAGGER);

    req_t             tap_s;
    logic [CNT_W-1:0] warm_cnt_r;
    logic             diff_s;
    logic             hit_s;
    logic             nxt_s;
    logic             flag_r;

    assign tap_s = hist_r[h*STAGGER-1];

    // Count enabled cycles until the history tap holds real hart-0 data.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        warm_cnt_r <= '0;
      end else if (!enable_i) begin
        warm_cnt_r <= '0;
      end else if (warm_cnt_r != WARM_C) begin
        warm_cnt_r <= warm_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        warm_cnt_r <= warm_cnt_r;
      end
    end

    // Compare rule: req must match; address phase only matters when both
    // request; write data only matters for a write.
    always_comb begin
      diff_s = 1'b0;
      if (tap_s.req != hart_req_i[h]) begin
        diff_s = 1'b1;
      end else if (tap_s.req) begin
        if ((tap_s.we != hart_we_i[h]) || (tap_s.be != hart_be_i[h]) ||
            (tap_s.addr != hart_addr_i[h])) begin
          diff_s = 1'b1;
        end else if (tap_s.we && (tap_s.wdata != hart_wdata_i[h])) begin
          diff_s = 1'b1;
        end else begin
          diff_s = 1'b0;
        end
      end else begin
        diff_s = 1'b0;
      end
    end

    assign hit_s = enable_i && (warm_cnt_r == WARM_C) && diff_s;

    // Sticky flag next state: a new mismatch beats a clear request.
    always_comb begin
      if (hit_s) begin
        nxt_s = 1'b1;
      end else if (clr_mismatch_i) begin
        nxt_s = 1'b0;
      end else begin
        nxt_s = flag_r;
      end
    end

    // Hold the per-hart sticky flag.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        flag_r <= 1'b0;
      end else begin
        flag_r <= nxt_s;
      end
    end

    assign flag_s[h]     = flag_r;
    assign flag_nxt_s[h] = nxt_s;
  end

  // Summary flag registered alongside the per-hart flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mismatch_r <= 1'b0;
    end else begin
      mismatch_r <= |flag_nxt_s;
    end
  end

  assign mismatch_hart_o = flag_s;
  assign mismatch_o      = mismatch_r;
`else
  // Comparator not built: trailing requests and the clear input are unused.
  logic unused_s;
  assign unused_s = ^{hart_req_i[NHARTS-1:1], hart_we_i[NHARTS-1:1],
                      hart_be_i[NHARTS-1:1], hart_addr_i[NHARTS-1:1],
                      hart_wdata_i[NHARTS-1:1], clr_mismatch_i};

  assign mismatch_hart_o = '0;
  assign mismatch_o      = 1'b0;
`endif

endmodule
